alu_issue: RTL and testbench

Initiator-side sequencer for the 32-bit combinational ALU in the EX stage. Accepts one operation per request handshake (2-bit ALUOp, 6-bit funct, two operands), decodes it to the 4-bit ALU control code, and drives the ALU ports from registered operands. It then captures the ALU result and zero flag and returns them through a response handshake. Sits between the decode/issue logic and the ALU, and is the only producer of the ALU's `src1`, `src2` and `ctrl` inputs.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_issue_if.sv | 37 +++
 rtl/alu_ctrl_dec.sv | 30 +++
 rtl/alu_issue.sv | 95 +++++++++
 tb/tb_alu_issue.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants: control codes, ALUOp/funct encodings and issue FSM states.
// Used by the ALU, its control decoder and the issue sequencer.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] CTRL_AND   = 4'd0;
    localparam logic [3:0] CTRL_OR    = 4'd1;
    localparam logic [3:0] CTRL_NAND  = 4'd2;
    localparam logic [3:0] CTRL_NOR   = 4'd3;
    localparam logic [3:0] CTRL_ADDU  = 4'd4;
    localparam logic [3:0] CTRL_SUBU  = 4'd5;
    localparam logic [3:0] CTRL_SLT   = 4'd6;
    localparam logic [3:0] CTRL_EQUAL = 4'd7;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       illegal;
    } alu_dec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } issue_state_e;

endpackage

// File: rtl/alu_issue_if.sv
// Request, ALU-port and response signals of the ALU issue sequencer.
// slave: the sequencer itself; master: issue logic, ALU and response consumer.
interface alu_issue_if;
    import alu_pkg::*;

    logic              req_valid_i;
    logic              req_ready_o;
    logic [1:0]        req_alu_op_i;
    logic [5:0]        req_funct_i;
    logic [DATA_W-1:0] req_src1_i;
    logic [DATA_W-1:0] req_src2_i;
    logic [DATA_W-1:0] alu_src1_o;
    logic [DATA_W-1:0] alu_src2_o;
    logic [3:0]        alu_ctrl_o;
    logic [DATA_W-1:0] alu_result_i;
    logic              alu_zero_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_result_o;
    logic              rsp_zero_o;
    logic              rsp_illegal_o;

    modport slave (
        input  req_valid_i, req_alu_op_i, req_funct_i, req_src1_i, req_src2_i,
        input  alu_result_i, alu_zero_i, rsp_ready_i,
        output req_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
        output rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_illegal_o
    );

    modport master (
        output req_valid_i, req_alu_op_i, req_funct_i, req_src1_i, req_src2_i,
        output alu_result_i, alu_zero_i, rsp_ready_i,
        input  req_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
        input  rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_illegal_o
    );

endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUOp/funct to ALU control decoder; flags any operation the ALU lacks.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output alu_dec_t   dec
);

    always_comb begin
        dec.ctrl    = CTRL_AND;
        dec.illegal = 1'b0;
        unique case (alu_op)
            ALUOP_ADD: dec.ctrl = CTRL_ADDU;
            ALUOP_SUB: dec.ctrl = CTRL_SUBU;
            ALUOP_SLT: dec.ctrl = CTRL_SLT;
            default: begin
                case (funct)
                    FUNCT_ADDU: dec.ctrl = CTRL_ADDU;
                    FUNCT_SUBU: dec.ctrl = CTRL_SUBU;
                    FUNCT_AND:  dec.ctrl = CTRL_AND;
                    FUNCT_OR:   dec.ctrl = CTRL_OR;
                    FUNCT_SLT:  dec.ctrl = CTRL_SLT;
                    default:    dec.illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Issue sequencer for the EX-stage ALU: registers operands/ctrl, waits one cycle
// for the combinational ALU, captures its result and hands it out on a response handshake.
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    alu_issue_if.slave  bus
);

    issue_state_e      state, state_nxt;
    alu_dec_t          dec;
    logic              ld_alu, ld_exec, ld_ill;
    logic [DATA_W-1:0] src1_q, src2_q, result_q;
    logic [3:0]        ctrl_q;
    logic              zero_q, illegal_q;

    alu_ctrl_dec u_dec (
        .alu_op (bus.req_alu_op_i),
        .funct  (bus.req_funct_i),
        .dec    (dec)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_alu    = 1'b0;
        ld_exec   = 1'b0;
        ld_ill    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    if (dec.illegal) begin
                        ld_ill    = 1'b1;
                        state_nxt = ST_RESP;
                    end else begin
                        ld_alu    = 1'b1;
                        state_nxt = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                ld_exec   = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Illegal requests leave the ALU ports untouched so the last op stays visible.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            src1_q <= '0;
            src2_q <= '0;
            ctrl_q <= '0;
        end else if (ld_alu) begin
            src1_q <= bus.req_src1_i;
            src2_q <= bus.req_src2_i;
            ctrl_q <= dec.ctrl;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (ld_exec) begin
            result_q  <= bus.alu_result_i;
            zero_q    <= bus.alu_zero_i;
            illegal_q <= 1'b0;
        end else if (ld_ill) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b1;
        end
    end

    assign bus.req_ready_o   = (state == ST_IDLE);
    assign bus.rsp_valid_o   = (state == ST_RESP);
    assign bus.alu_src1_o    = src1_q;
    assign bus.alu_src2_o    = src2_q;
    assign bus.alu_ctrl_o    = ctrl_q;
    assign bus.rsp_result_o  = result_q;
    assign bus.rsp_zero_o    = zero_q;
    assign bus.rsp_illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: an ALU stand-in on the ALU ports, directed scenarios and random ops
// scored against an operation-level reference model.
module tb_alu_issue;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    // Stand-in for the EX-stage ALU: only the codes it implements.
    always_comb begin
        case (bus.alu_ctrl_o)
            4'd0:    bus.alu_result_i = bus.alu_src1_o & bus.alu_src2_o;
            4'd1:    bus.alu_result_i = bus.alu_src1_o | bus.alu_src2_o;
            4'd4:    bus.alu_result_i = bus.alu_src1_o + bus.alu_src2_o;
            4'd5:    bus.alu_result_i = bus.alu_src1_o - bus.alu_src2_o;
            4'd6:    bus.alu_result_i = {31'd0, bus.alu_src1_o < bus.alu_src2_o};
            default: bus.alu_result_i = 32'hDEAD_BEEF;
        endcase
        bus.alu_zero_i = (bus.alu_result_i == 32'd0);
    end

    function automatic void ref_op(input logic [1:0] op, input logic [5:0] f,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic z,
                                   output logic ill, output logic [3:0] c);
        ill = 1'b0; c = 4'd0; r = 32'd0;
        case (op)
            2'd0: begin c = 4'd4; r = a + b; end
            2'd1: begin c = 4'd5; r = a - b; end
            2'd3: begin c = 4'd6; r = (a < b) ? 32'd1 : 32'd0; end
            default: begin
                case (f)
                    6'h21: begin c = 4'd4; r = a + b; end
                    6'h23: begin c = 4'd5; r = a - b; end
                    6'h24: begin c = 4'd0; r = a & b; end
                    6'h25: begin c = 4'd1; r = a | b; end
                    6'h2A: begin c = 4'd6; r = (a < b) ? 32'd1 : 32'd0; end
                    default: ill = 1'b1;
                endcase
            end
        endcase
        if (ill) begin r = 32'd0; z = 1'b1; end
        else z = (r == 32'd0);
    endfunction

    // Issue one request; lat = edges after acceptance until rsp_valid (-1 on timeout).
    task automatic run_op(input logic [1:0] op, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [3:0] ctrl_seen);
        logic acc;
        acc = 1'b0;
        bus.req_alu_op_i = op; bus.req_funct_i = f;
        bus.req_src1_i = a; bus.req_src2_i = b;
        bus.req_valid_i = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = bus.req_ready_o;
            @(posedge clk); #1;
        end
        bus.req_valid_i = 1'b0;
        ctrl_seen = bus.alu_ctrl_o;
        lat = 0;
        if (!acc) lat = -1;
        else begin
            while (!bus.rsp_valid_o && lat < 8) begin
                @(posedge clk); #1;
                lat++;
            end
            if (!bus.rsp_valid_o) lat = -1;
        end
    endtask

    task automatic rsp_accept();
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0 || bus.alu_ctrl_o !== 4'd0 ||
            bus.alu_src1_o !== 32'd0 || bus.rsp_result_o !== 32'd0 || bus.rsp_illegal_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: ready=%b valid=%b ctrl=%0d src1=%h res=%h ill=%b, required 1 0 0 0 0 0",
                     bus.req_ready_o, bus.rsp_valid_o, bus.alu_ctrl_o, bus.alu_src1_o,
                     bus.rsp_result_o, bus.rsp_illegal_o);
        end
    endtask

    task automatic test_legal(input string name, input logic [1:0] op, input logic [5:0] f,
                              input logic [31:0] a, input logic [31:0] b);
        int lat; logic [3:0] cs, ec; logic [31:0] er; logic ez, ei;
        ref_op(op, f, a, b, er, ez, ei, ec);
        run_op(op, f, a, b, lat, cs);
        n_checks++;
        if (lat !== 1 || cs !== ec) begin
            n_fail++;
            $display("FAIL %s latency/ctrl: lat=%0d ctrl=%0d, required 1 %0d", name, lat, cs, ec);
        end
        n_checks++;
        if (bus.rsp_result_o !== er || bus.rsp_zero_o !== ez || bus.rsp_illegal_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s response: res=%h zero=%b ill=%b, required %h %b 0",
                     name, bus.rsp_result_o, bus.rsp_zero_o, bus.rsp_illegal_o, er, ez);
        end
        rsp_accept();
        n_checks++;
        if (bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s return to idle: ready=%b valid=%b, required 1 0",
                     name, bus.req_ready_o, bus.rsp_valid_o);
        end
    endtask

    task automatic test_illegal();
        int lat; logic [3:0] cs, prev;
        prev = bus.alu_ctrl_o;
        run_op(2'b10, 6'h27, 32'h1234, 32'h5678, lat, cs);
        n_checks++;
        if (lat !== 0 || cs !== prev) begin
            n_fail++;
            $display("FAIL illegal latency/ctrl: lat=%0d ctrl=%0d, required 0 %0d", lat, cs, prev);
        end
        n_checks++;
        if (bus.rsp_result_o !== 32'd0 || bus.rsp_zero_o !== 1'b1 || bus.rsp_illegal_o !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal response: res=%h zero=%b ill=%b, required 0 1 1",
                     bus.rsp_result_o, bus.rsp_zero_o, bus.rsp_illegal_o);
        end
        rsp_accept();
    endtask

    task automatic test_stall();
        int lat; logic [3:0] cs; int bad;
        run_op(2'b00, 6'h00, 32'd7, 32'd8, lat, cs);
        bus.req_alu_op_i = 2'b00; bus.req_src1_i = 32'd100; bus.req_src2_i = 32'd23;
        bus.req_valid_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid_o !== 1'b1 || bus.rsp_result_o !== 32'd15 || bus.req_ready_o !== 1'b0 ||
                bus.alu_src1_o !== 32'd7) bad++;
        end
        n_checks++;
        if (lat !== 1 || bad != 0) begin
            n_fail++;
            $display("FAIL stall hold: lat=%0d bad_cycles=%0d res=%h, required 1 0 0000000f",
                     lat, bad, bus.rsp_result_o);
        end
        rsp_accept();
        n_checks++;
        if (bus.req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall release idle: ready=%b, required 1", bus.req_ready_o);
        end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        n_checks++;
        if (bus.req_ready_o !== 1'b0 || bus.alu_src1_o !== 32'd100 || bus.alu_ctrl_o !== 4'd4) begin
            n_fail++;
            $display("FAIL stall second accept: ready=%b src1=%h ctrl=%0d, required 0 00000064 4",
                     bus.req_ready_o, bus.alu_src1_o, bus.alu_ctrl_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.rsp_valid_o !== 1'b1 || bus.rsp_result_o !== 32'd123) begin
            n_fail++;
            $display("FAIL stall second result: valid=%b res=%h, required 1 0000007b",
                     bus.rsp_valid_o, bus.rsp_result_o);
        end
        rsp_accept();
    endtask

    task automatic test_reset_mid_resp();
        int lat; logic [3:0] cs;
        run_op(2'b00, 6'h00, 32'd2, 32'd3, lat, cs);
        n_checks++;
        if (lat !== 1 || bus.rsp_result_o !== 32'd5) begin
            n_fail++;
            $display("FAIL pre-reset result: lat=%0d res=%h, required 1 00000005", lat, bus.rsp_result_o);
        end
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1 || bus.rsp_result_o !== 32'd0 ||
            bus.alu_ctrl_o !== 4'd0 || bus.alu_src1_o !== 32'd0 || bus.rsp_zero_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset mid resp: valid=%b ready=%b res=%h ctrl=%0d src1=%h zero=%b, required 0 1 0 0 0 0",
                     bus.rsp_valid_o, bus.req_ready_o, bus.rsp_result_o, bus.alu_ctrl_o,
                     bus.alu_src1_o, bus.rsp_zero_o);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        test_legal("post_reset", 2'b01, 6'h00, 32'd10, 32'd4);
    endtask

    task automatic test_random();
        logic [5:0] fl [7];
        logic [1:0] op; logic [5:0] f; logic [31:0] a, b, er; logic ez, ei; logic [3:0] ec, cs;
        int lat, bad;
        fl = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00};
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            f  = fl[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) f = 6'($urandom);
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 5) == 0) b = a;
            ref_op(op, f, a, b, er, ez, ei, ec);
            run_op(op, f, a, b, lat, cs);
            n_checks++;
            if (lat !== (ei ? 0 : 1) || bus.rsp_result_o !== er || bus.rsp_zero_o !== ez ||
                bus.rsp_illegal_o !== ei || (!ei && cs !== ec)) begin
                n_fail++; bad++;
                if (bad < 5)
                    $display("FAIL random op=%0d f=%h a=%h b=%h: lat=%0d res=%h z=%b ill=%b ctrl=%0d, required %0d %h %b %b %0d",
                             op, f, a, b, lat, bus.rsp_result_o, bus.rsp_zero_o, bus.rsp_illegal_o, cs,
                             ei ? 0 : 1, er, ez, ei, ec);
            end
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
            rsp_accept();
        end
    endtask

    initial begin
        bus.req_valid_i = 1'b0; bus.req_alu_op_i = '0; bus.req_funct_i = '0;
        bus.req_src1_i = '0; bus.req_src2_i = '0; bus.rsp_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_legal("addu_overflow", 2'b10, 6'h21, 32'h7FFF_FFFF, 32'h0000_0001);
        test_legal("sub_equal", 2'b01, 6'h00, 32'h1234_5678, 32'h1234_5678);
        test_legal("add_wrap", 2'b00, 6'h3F, 32'hFFFF_FFFF, 32'h0000_0001);
        test_legal("slt_rtype", 2'b10, 6'h2A, 32'd1, 32'd2);
        test_legal("and_rtype", 2'b10, 6'h24, 32'hF0F0_0F0F, 32'hFF00_FF00);
        test_illegal();
        test_stall();
        test_reset_mid_resp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
